// File: rtl/mcycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU ops, mux selects, state enum.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mcycle_ctrl_pkg;

    // Opcodes (low 6 bits of the instruction opcode field)
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_XOR  = 6'b000100;
    localparam logic [5:0] OP_SLT  = 6'b000101;
    localparam logic [5:0] OP_SLTU = 6'b000110;
    localparam logic [5:0] OP_SLLI = 6'b001000;
    localparam logic [5:0] OP_SRLI = 6'b001001;
    localparam logic [5:0] OP_SRAI = 6'b001010;
    localparam logic [5:0] OP_ADDI = 6'b010000;
    localparam logic [5:0] OP_ANDI = 6'b010010;
    localparam logic [5:0] OP_ORI  = 6'b010011;
    localparam logic [5:0] OP_XORI = 6'b010100;
    localparam logic [5:0] OP_SLTI = 6'b010101;
    localparam logic [5:0] OP_LUI  = 6'b010111;
    localparam logic [5:0] OP_BEQ  = 6'b011000;
    localparam logic [5:0] OP_BNE  = 6'b011001;
    localparam logic [5:0] OP_BLT  = 6'b011010;
    localparam logic [5:0] OP_JAL  = 6'b011100;
    localparam logic [5:0] OP_JALR = 6'b011101;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100010;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SW   = 6'b101010;

    // ALU control encodings (5-bit core, zero-extended to ALUCW)
    localparam logic [4:0] ALU_AND  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_XOR  = 5'd3;
    localparam logic [4:0] ALU_SLL  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_SUB  = 5'd6;
    localparam logic [4:0] ALU_SLT  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_TRAP   = 2'b10;

    // Register write-back source select
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    // Register write strobe / size codes
    localparam logic [2:0] RW_NONE = 3'b000;
    localparam logic [2:0] RW_LBU  = 3'b001;
    localparam logic [2:0] RW_LB   = 3'b010;
    localparam logic [2:0] RW_LHU  = 3'b011;
    localparam logic [2:0] RW_LH   = 3'b100;
    localparam logic [2:0] RW_W    = 3'b101;

    // Memory write strobe / size codes
    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_B    = 2'b01;
    localparam logic [1:0] MW_H    = 2'b10;
    localparam logic [1:0] MW_W    = 2'b11;

    typedef enum logic [2:0] {
        CLS_RTYPE, CLS_SHIFT, CLS_IMM, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LOAD, CLS_STORE
    } opclass_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC, S_ALUWB,
        S_SLTWB, S_SHEXEC, S_BRANCH, S_IEXEC, S_LINK, S_JALRJ, S_JALJ, S_TRAP
    } state_t;

endpackage

// File: rtl/mcycle_ctrl_dec.sv
// Opcode-to-class decoder: class, legality, ALU op and load/store size codes.
// Latency: purely combinational.
// Backpressure: none.
module mcycle_ctrl_dec
    import mcycle_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output opclass_t       cls,
    output logic           legal,
    output logic [4:0]     alucontrol,
    output logic           is_slt,
    output logic [2:0]     rwsize,
    output logic [1:0]     mwsize
);

    logic [5:0] op;
    logic       known;
    logic       upper_zero;

    assign op         = opcode[5:0];
    // Any set bit above the 6 decoded bits makes the opcode illegal.
    assign upper_zero = ((opcode >> 6) == '0);
    assign legal      = known & upper_zero;

    always_comb begin
        cls        = CLS_RTYPE;
        known      = 1'b1;
        alucontrol = ALU_ADD;
        is_slt     = 1'b0;
        rwsize     = RW_W;
        mwsize     = MW_W;
        case (op)
            OP_ADD:  alucontrol = ALU_ADD;
            OP_SUB:  alucontrol = ALU_SUB;
            OP_AND:  alucontrol = ALU_AND;
            OP_OR:   alucontrol = ALU_OR;
            OP_XOR:  alucontrol = ALU_XOR;
            OP_SLT:  begin alucontrol = ALU_SLT;  is_slt = 1'b1; end
            OP_SLTU: begin alucontrol = ALU_SLTU; is_slt = 1'b1; end
            OP_SLLI: begin cls = CLS_SHIFT; alucontrol = ALU_SLL; end
            OP_SRLI: begin cls = CLS_SHIFT; alucontrol = ALU_SRL; end
            OP_SRAI: begin cls = CLS_SHIFT; alucontrol = ALU_SRA; end
            OP_ADDI: begin cls = CLS_IMM; alucontrol = ALU_ADD; end
            OP_ANDI: begin cls = CLS_IMM; alucontrol = ALU_AND; end
            OP_ORI:  begin cls = CLS_IMM; alucontrol = ALU_OR;  end
            OP_XORI: begin cls = CLS_IMM; alucontrol = ALU_XOR; end
            OP_SLTI: begin cls = CLS_IMM; alucontrol = ALU_SLT; end
            OP_LUI:  begin cls = CLS_IMM; alucontrol = ALU_LUI; end
            OP_BEQ:  begin cls = CLS_BRANCH; alucontrol = ALU_SUB; end
            OP_BNE:  begin cls = CLS_BRANCH; alucontrol = ALU_SUB; end
            OP_BLT:  begin cls = CLS_BRANCH; alucontrol = ALU_SLT; end
            OP_JAL:  cls = CLS_JAL;
            OP_JALR: cls = CLS_JALR;
            OP_LB:   begin cls = CLS_LOAD; rwsize = RW_LB;  end
            OP_LH:   begin cls = CLS_LOAD; rwsize = RW_LH;  end
            OP_LW:   begin cls = CLS_LOAD; rwsize = RW_W;   end
            OP_LBU:  begin cls = CLS_LOAD; rwsize = RW_LBU; end
            OP_LHU:  begin cls = CLS_LOAD; rwsize = RW_LHU; end
            OP_SB:   begin cls = CLS_STORE; mwsize = MW_B; end
            OP_SH:   begin cls = CLS_STORE; mwsize = MW_H; end
            OP_SW:   begin cls = CLS_STORE; mwsize = MW_W; end
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multicycle CPU control FSM (Moore, with mem_ready-qualified fetch strobes); macro MCYCLE_CTRL_TRAP_EN enables the trap vector.
// Latency: one state per cycle; FETCH/MEMRD/MEMWR stall until mem_ready.
// Backpressure: mem_req held with the same outputs until mem_ready; reset low forces all outputs 0.
// Ports: clk, reset (sync active-low), opcode/flag/mem_ready in; datapath selects, write strobes, mem_req, trap out.
module mcycle_ctrl
    import mcycle_ctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int ALUCW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic             flag,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             iord,
    output logic             regdst,
    output logic [1:0]       memtoreg,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [ALUCW-1:0] alucontrol,
    output logic [1:0]       pcsrc,
    output logic [1:0]       memwrite,
    output logic             irwrite,
    output logic [2:0]       regwrite,
    output logic             mem_req,
    output logic             trap
);

    state_t     state;
    opclass_t   cls;
    logic       legal;
    logic [4:0] dec_alu;
    logic       is_slt;
    logic [2:0] rwsize;
    logic [1:0] mwsize;
    logic       pcwrite;
    logic       branch;
    logic [4:0] alu5;

    mcycle_ctrl_dec #(.OPW(OPW)) u_dec (
        .opcode     (opcode),
        .cls        (cls),
        .legal      (legal),
        .alucontrol (dec_alu),
        .is_slt     (is_slt),
        .rwsize     (rwsize),
        .mwsize     (mwsize)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (!legal) state <= S_TRAP;
                    else begin
                        case (cls)
                            CLS_RTYPE:  state <= S_REXEC;
                            CLS_SHIFT:  state <= S_SHEXEC;
                            CLS_IMM:    state <= S_IEXEC;
                            CLS_BRANCH: state <= S_BRANCH;
                            CLS_JAL,
                            CLS_JALR:   state <= S_LINK;
                            default:    state <= S_MEMADR;
                        endcase
                    end
                end
                S_MEMADR: state <= (cls == CLS_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_REXEC:  state <= is_slt ? S_SLTWB : S_ALUWB;
                S_SHEXEC,
                S_IEXEC:  state <= S_ALUWB;
                S_LINK:   state <= (cls == CLS_JALR) ? S_JALRJ : S_JALJ;
                default:  state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = M2R_ALU;
        alusrca  = 2'b00;
        alusrcb  = 2'b00;
        alu5     = 5'd0;
        pcsrc    = PCSRC_ALU;
        memwrite = MW_NONE;
        irwrite  = 1'b0;
        regwrite = RW_NONE;
        mem_req  = 1'b0;
        trap     = 1'b0;
        // Outputs stay quiet while reset is asserted so a reset landing mid-store
        // never emits a write strobe.
        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    alu5    = ALU_ADD;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin alusrcb = 2'b10; alu5 = ALU_ADD; end
                S_MEMADR: begin alusrca = 2'b10; alusrcb = 2'b10; alu5 = ALU_ADD; end
                S_MEMRD:  begin mem_req = 1'b1; iord = 1'b1; end
                S_MEMWB:  begin memtoreg = M2R_MEM; regwrite = rwsize; end
                S_MEMWR:  begin mem_req = 1'b1; iord = 1'b1; memwrite = mwsize; end
                S_REXEC:  begin alusrca = 2'b10; alu5 = dec_alu; end
                S_SHEXEC,
                S_IEXEC:  begin alusrca = 2'b10; alusrcb = 2'b10; alu5 = dec_alu; end
                S_ALUWB:  regwrite = RW_W;
                S_SLTWB:  begin regdst = 1'b1; regwrite = RW_W; end
                S_BRANCH: begin alusrca = 2'b10; alu5 = dec_alu; branch = 1'b1; pcsrc = PCSRC_ALUOUT; end
                S_LINK:   begin memtoreg = M2R_PC; regwrite = RW_W; end
                S_JALRJ:  begin alusrca = 2'b10; alusrcb = 2'b10; alu5 = ALU_ADD; pcwrite = 1'b1; end
                S_JALJ:   begin alusrcb = 2'b11; alu5 = ALU_ADD; pcwrite = 1'b1; end
                S_TRAP: begin
`ifdef MCYCLE_CTRL_TRAP_EN
                    trap    = 1'b1;
                    pcsrc   = PCSRC_TRAP;
                    pcwrite = 1'b1;
`else
                    // Illegal opcode retires as a NOP.
                    trap    = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign pcen       = pcwrite | (branch & flag);
    assign alucontrol = ALUCW'(alu5);

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed self-checking bench for mcycle_ctrl.
// Latency: n/a.
// Backpressure: mem_ready stalls driven from per-test tables.
module tb_mcycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       flag;
    logic       mem_ready;
    logic       pcen, iord, regdst, irwrite, mem_req, trap;
    logic [1:0] memtoreg, alusrca, alusrcb, pcsrc, memwrite;
    logic [4:0] alucontrol;
    logic [2:0] regwrite;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mcycle_ctrl #(.OPW(6), .ALUCW(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .flag(flag), .mem_ready(mem_ready),
        .pcen(pcen), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .mem_req(mem_req), .trap(trap)
    );

    // Packed view of every output: {pcen,iord,regdst,memtoreg,alusrca,alusrcb,alucontrol,pcsrc,memwrite,irwrite,regwrite,mem_req,trap}
    wire [23:0] obs = {pcen, iord, regdst, memtoreg, alusrca, alusrcb, alucontrol,
                       pcsrc, memwrite, irwrite, regwrite, mem_req, trap};

    // Hand-chosen encodings
    localparam logic [4:0] A_ADD = 5'd2, A_OR = 5'd1, A_SUB = 5'd6, A_SLT = 5'd7;

    function automatic logic [23:0] ev(input logic pe, io, rd, input logic [1:0] m2r, asa, asb,
                                       input logic [4:0] al, input logic [1:0] ps, mw,
                                       input logic irw, input logic [2:0] rw, input logic mrq, tp);
        return {pe, io, rd, m2r, asa, asb, al, ps, mw, irw, rw, mrq, tp};
    endfunction

    function automatic logic [23:0] e_fetch(input logic r);
        return ev(r, 0, 0, 2'b00, 2'b00, 2'b01, A_ADD, 2'b00, 2'b00, r, 3'b000, 1, 0);
    endfunction

    function automatic logic [23:0] e_dec();
        return ev(0, 0, 0, 2'b00, 2'b00, 2'b10, A_ADD, 2'b00, 2'b00, 0, 3'b000, 0, 0);
    endfunction

    // One cycle: drive inputs at the falling edge, settle, then sample.
    task automatic cyc(input logic rst, input logic mr, input logic fl);
        @(negedge clk);
        reset = rst; mem_ready = mr; flag = fl;
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] e [0:4];
        logic [4:0] rs = 5'b11100;
        e[0] = 24'h0; e[1] = 24'h0;
        e[2] = e_fetch(0); e[3] = e_fetch(0); e[4] = e_fetch(0);
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            cyc(rs[i], 0, 0);
            checks++;
            if (obs !== e[i]) $display("FAIL reset c%0d got=%h want=%h", i, obs, e[i]);
            else passes++;
        end
    endtask

    task automatic test_add();
        logic [23:0] e [0:4];
        logic [4:0] mr = 5'b01111;
        opcode = 6'b000000;
        e[0] = e_fetch(1); e[1] = e_dec();
        e[2] = ev(0, 0, 0, 2'b00, 2'b10, 2'b00, A_ADD, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e[3] = ev(0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd0, 2'b00, 2'b00, 0, 3'b101, 0, 0);
        e[4] = e_fetch(0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, mr[i], 0);
            checks++;
            if (obs !== e[i]) $display("FAIL add c%0d got=%h want=%h", i, obs, e[i]);
            else passes++;
        end
    endtask

    task automatic test_slt();
        logic [23:0] e [0:4];
        opcode = 6'b000101;
        e[0] = e_fetch(1); e[1] = e_dec();
        e[2] = ev(0, 0, 0, 2'b00, 2'b10, 2'b00, A_SLT, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e[3] = ev(0, 0, 1, 2'b00, 2'b00, 2'b00, 5'd0, 2'b00, 2'b00, 0, 3'b101, 0, 0);
        e[4] = e_fetch(0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, (i < 4), 0);
            checks++;
            if (obs !== e[i]) $display("FAIL slt c%0d got=%h want=%h", i, obs, e[i]);
            else passes++;
        end
    endtask

    task automatic test_imm();
        logic [23:0] e [0:4];
        opcode = 6'b010011;  // ORI
        e[0] = e_fetch(1); e[1] = e_dec();
        e[2] = ev(0, 0, 0, 2'b00, 2'b10, 2'b10, A_OR, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e[3] = ev(0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd0, 2'b00, 2'b00, 0, 3'b101, 0, 0);
        e[4] = e_fetch(0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, (i < 4), 0);
            checks++;
            if (obs !== e[i]) $display("FAIL ori c%0d got=%h want=%h", i, obs, e[i]);
            else passes++;
        end
    endtask

    task automatic test_lw_stall();
        logic [23:0] e [0:8];
        logic [8:0] mr = 9'b001000111;  // bit i = mem_ready in cycle i
        logic [23:0] rd = ev(0, 1, 0, 2'b00, 2'b00, 2'b00, 5'd0, 2'b00, 2'b00, 0, 3'b000, 1, 0);
        opcode = 6'b100010;
        e[0] = e_fetch(1); e[1] = e_dec();
        e[2] = ev(0, 0, 0, 2'b00, 2'b10, 2'b10, A_ADD, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e[3] = rd; e[4] = rd; e[5] = rd; e[6] = rd;
        e[7] = ev(0, 0, 0, 2'b01, 2'b00, 2'b00, 5'd0, 2'b00, 2'b00, 0, 3'b101, 0, 0);
        e[8] = e_fetch(0);
        mr[6] = 1'b1; mr[7] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(1, mr[i], 0);
            checks++;
            if (obs !== e[i]) $display("FAIL lw c%0d got=%h want=%h", i, obs, e[i]);
            else passes++;
        end
    endtask

    task automatic test_load_sizes();
        logic [5:0] ops [0:3];
        logic [2:0] rws [0:3];
        logic [23:0] ew;
        ops[0] = 6'b100000; rws[0] = 3'b010;  // LB
        ops[1] = 6'b100001; rws[1] = 3'b100;  // LH
        ops[2] = 6'b100100; rws[2] = 3'b001;  // LBU
        ops[3] = 6'b100101; rws[3] = 3'b011;  // LHU
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 4; i++) cyc(1, 1, 0);  // FETCH, DECODE, MEMADR, MEMRD
            cyc(1, 0, 0);                              // MEMWB
            ew = ev(0, 0, 0, 2'b01, 2'b00, 2'b00, 5'd0, 2'b00, 2'b00, 0, rws[k], 0, 0);
            checks++;
            if (obs !== ew) $display("FAIL ldsize%0d got=%h want=%h", k, obs, ew);
            else passes++;
            cyc(1, 0, 0);                              // FETCH, idle
        end
    endtask

    task automatic test_sh_stall();
        logic [23:0] e [0:6];
        logic [6:0] mr = 7'b0100111;
        logic [23:0] wr = ev(0, 1, 0, 2'b00, 2'b00, 2'b00, 5'd0, 2'b00, 2'b10, 0, 3'b000, 1, 0);
        opcode = 6'b101001;
        e[0] = e_fetch(1); e[1] = e_dec();
        e[2] = ev(0, 0, 0, 2'b00, 2'b10, 2'b10, A_ADD, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e[3] = wr; e[4] = wr; e[5] = wr;
        e[6] = e_fetch(0);
        mr[3] = 1'b0; mr[4] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(1, mr[i], 0);
            checks++;
            if (obs !== e[i]) $display("FAIL sh c%0d got=%h want=%h", i, obs, e[i]);
            else passes++;
        end
    endtask

    task automatic test_branch();
        logic [23:0] e [0:3];
        opcode = 6'b011000;  // BEQ
        for (int f = 1; f >= 0; f--) begin
            e[0] = e_fetch(1); e[1] = e_dec();
            e[2] = ev(f[0], 0, 0, 2'b00, 2'b10, 2'b00, A_SUB, 2'b01, 2'b00, 0, 3'b000, 0, 0);
            e[3] = e_fetch(0);
            for (int i = 0; i < 4; i++) begin
                cyc(1, (i < 3), f[0]);
                checks++;
                if (obs !== e[i]) $display("FAIL beq f%0d c%0d got=%h want=%h", f, i, obs, e[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_jump();
        logic [23:0] e [0:4];
        for (int j = 0; j < 2; j++) begin
            opcode = (j == 0) ? 6'b011100 : 6'b011101;  // JAL, JALR
            e[0] = e_fetch(1); e[1] = e_dec();
            e[2] = ev(0, 0, 0, 2'b10, 2'b00, 2'b00, 5'd0, 2'b00, 2'b00, 0, 3'b101, 0, 0);
            e[3] = (j == 0) ? ev(1, 0, 0, 2'b00, 2'b00, 2'b11, A_ADD, 2'b00, 2'b00, 0, 3'b000, 0, 0)
                            : ev(1, 0, 0, 2'b00, 2'b10, 2'b10, A_ADD, 2'b00, 2'b00, 0, 3'b000, 0, 0);
            e[4] = e_fetch(0);
            for (int i = 0; i < 5; i++) begin
                cyc(1, (i < 4), 0);
                checks++;
                if (obs !== e[i]) $display("FAIL jump%0d c%0d got=%h want=%h", j, i, obs, e[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_trap();
        logic [23:0] e [0:3];
        opcode = 6'b111000;
        e[0] = e_fetch(1); e[1] = e_dec();
`ifdef MCYCLE_CTRL_TRAP_EN
        e[2] = ev(1, 0, 0, 2'b00, 2'b00, 2'b00, 5'd0, 2'b10, 2'b00, 0, 3'b000, 0, 1);
`else
        e[2] = 24'h0;
`endif
        e[3] = e_fetch(0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, (i < 3), 1);
            checks++;
            if (obs !== e[i]) $display("FAIL trap c%0d got=%h want=%h", i, obs, e[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_memwr();
        logic [23:0] e [0:5];
        logic [5:0] rs = 6'b101111;
        logic [5:0] mr = 6'b000111;
        opcode = 6'b101010;  // SW
        e[0] = e_fetch(1); e[1] = e_dec();
        e[2] = ev(0, 0, 0, 2'b00, 2'b10, 2'b10, A_ADD, 2'b00, 2'b00, 0, 3'b000, 0, 0);
        e[3] = ev(0, 1, 0, 2'b00, 2'b00, 2'b00, 5'd0, 2'b00, 2'b11, 0, 3'b000, 1, 0);
        e[4] = 24'h0;
        e[5] = e_fetch(0);
        for (int i = 0; i < 6; i++) begin
            cyc(rs[i], mr[i], 0);
            checks++;
            if (obs !== e[i]) $display("FAIL rst_memwr c%0d got=%h want=%h", i, obs, e[i]);
            else passes++;
        end
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; flag = 1'b0; opcode = 6'b000000;
        test_reset();
        test_add();
        test_slt();
        test_imm();
        test_lw_stall();
        test_load_sizes();
        test_sh_stall();
        test_branch();
        test_jump();
        test_trap();
        test_reset_memwr();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
